// File: rtl/fx3_stream_pkg.sv
// Shared types and constants for the FX3 IQ streaming blocks.
package fx3_stream_pkg;

  // IQ sample width: I in [11:0], Q in [23:12].
  localparam int IQ_W = 24;

  // Number of arbitrated sample channels.
  localparam int N_CH = 2;

  // Channel index type (two channels -> one bit).
  typedef logic ch_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Map a channel index to its grant state.
  function automatic state_t gnt_state(input ch_t ch);
    return ch ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/fx3_rr_pick.sv
// Two-way round-robin picker: on a tie the channel not served last wins.
module fx3_rr_pick
  import fx3_stream_pkg::*;
(
  input  logic [1:0] cand,
  input  ch_t        last,
  output ch_t        gnt_idx,
  output logic       gnt_vld
);

  // Pure combinational choice between the two candidates.
  always_comb begin
    gnt_vld = |cand;
    gnt_idx = last;
    case (cand)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = last;
    endcase
  end

endmodule

// File: rtl/fx3_iq_arbiter.sv
// Burst arbiter merging two IQ sample streams onto one downstream port.
// A granted channel is passed through combinationally; a grant ends on the
// final beat of a full burst or after IDLE_TO consecutive empty cycles.
module fx3_iq_arbiter
  import fx3_stream_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int IDLE_TO = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_ch_en,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [IQ_W-1:0]    s0_data_i,
  input  logic               s0_valid_i,
  output logic               s0_ready_o,
  input  logic [IQ_W-1:0]    s1_data_i,
  input  logic               s1_valid_i,
  output logic               s1_ready_o,
  output logic [IQ_W-1:0]    m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               m_ch_o,
  output logic               m_last_o
);

  localparam int IDLE_W = $clog2(IDLE_TO + 1);
  localparam logic [BURST_W-1:0] BEAT_ONE   = BURST_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_ONE   = IDLE_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(IDLE_TO);

  state_t             state_reg, state_next;
  ch_t                last_reg, last_next;
  logic [BURST_W-1:0] len_reg, len_next;
  logic [BURST_W-1:0] beat_reg, beat_next;
  logic [IDLE_W-1:0]  idle_reg, idle_next;
  logic [IQ_W-1:0]    hold_reg, hold_next;

  // Channel inputs gathered into arrays so the datapath can index them.
  logic [IQ_W-1:0] s_data [N_CH];
  logic [N_CH-1:0] s_valid;
  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] ready;

  assign s_data[0]  = s0_data_i;
  assign s_data[1]  = s1_data_i;
  assign s_valid[0] = s0_valid_i;
  assign s_valid[1] = s1_valid_i;
  assign s0_ready_o = ready[0];
  assign s1_ready_o = ready[1];

  // Grant decode; reset suppresses the pass-through immediately.
  logic            granted;
  ch_t             gnt_ch;
  logic            sel_valid;
  logic [IQ_W-1:0] sel_data;
  logic            at_last;
  logic [IDLE_W-1:0] idle_inc;

  assign granted   = (state_reg != IDLE) & ~rst;
  assign gnt_ch    = ch_t'(state_reg == GNT1);
  assign sel_valid = s_valid[gnt_ch];
  assign sel_data  = s_data[gnt_ch];
  // Length 0 wraps to all-ones here, which is exactly the 2^BURST_W case.
  assign at_last   = (beat_reg == (len_reg - BEAT_ONE));
  assign idle_inc  = idle_reg + IDLE_ONE;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign cand[gi]  = cfg_ch_en[gi] & s_valid[gi];
      assign ready[gi] = granted & (gnt_ch == ch_t'(gi)) & m_ready_i;
    end
  endgenerate

  ch_t  pick_idx;
  logic pick_vld;

  fx3_rr_pick u_pick (
    .cand    (cand),
    .last    (last_reg),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // State, counters and the held output sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      len_reg   <= '0;
      beat_reg  <= '0;
      idle_reg  <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      len_reg   <= len_next;
      beat_reg  <= beat_next;
      idle_reg  <= idle_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state, counter updates and downstream outputs.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    len_next   = len_reg;
    beat_next  = beat_reg;
    idle_next  = idle_reg;
    hold_next  = hold_reg;
    m_data_o   = hold_reg;
    m_valid_o  = 1'b0;
    m_last_o   = 1'b0;
    m_ch_o     = last_reg;

    case (state_reg)
      IDLE: begin
        if (pick_vld) begin
          state_next = gnt_state(pick_idx);
          len_next   = cfg_burst_len;
          beat_next  = '0;
          idle_next  = '0;
        end
      end
      GNT0, GNT1: begin
        m_data_o  = sel_data;
        m_valid_o = sel_valid;
        m_ch_o    = gnt_ch;
        m_last_o  = sel_valid & at_last;
        if (sel_valid) begin
          // A present beat, stalled or not, is never idle time.
          idle_next = '0;
          if (m_ready_i) begin
            hold_next = sel_data;
            beat_next = beat_reg + BEAT_ONE;
            if (at_last) begin
              state_next = IDLE;
              last_next  = gnt_ch;
              beat_next  = '0;
            end
          end
        end else if (idle_inc == IDLE_LIMIT) begin
          // Source went quiet for too long: revoke as a short burst.
          state_next = IDLE;
          last_next  = gnt_ch;
          beat_next  = '0;
          idle_next  = '0;
        end else begin
          idle_next = idle_inc;
        end
      end
      default: state_next = IDLE;
    endcase

    if (rst) begin
      m_data_o  = '0;
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_ch_o    = 1'b1;
    end
  end

endmodule

// File: tb/tb_fx3_iq_arbiter.sv
// Directed bench for fx3_iq_arbiter: a per-cycle vector table for the
// alternating-burst / channel-disable flow plus hand sequences for the
// long burst, idle timeout, stalled burst and mid-burst reset cases.
module tb_fx3_iq_arbiter;
  import fx3_stream_pkg::*;

  localparam int BURST_W = 8;
  localparam int IDLE_TO = 16;
  localparam logic [23:0] D0 = 24'h3A51C7;
  localparam logic [23:0] D1 = 24'h6E20B4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         cfg_ch_en = 2'b00;
  logic [BURST_W-1:0] cfg_burst_len = 8'd4;
  logic [23:0]        s0_data = D0;
  logic               s0_valid = 1'b0;
  logic               s0_ready;
  logic [23:0]        s1_data = D1;
  logic               s1_valid = 1'b0;
  logic               s1_ready;
  logic [23:0]        m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               m_ch;
  logic               m_last;

  fx3_iq_arbiter #(.BURST_W(BURST_W), .IDLE_TO(IDLE_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_ch_en     (cfg_ch_en),
    .cfg_burst_len (cfg_burst_len),
    .s0_data_i     (s0_data),
    .s0_valid_i    (s0_valid),
    .s0_ready_o    (s0_ready),
    .s1_data_i     (s1_data),
    .s1_valid_i    (s1_valid),
    .s1_ready_o    (s1_ready),
    .m_data_o      (m_data),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_ch_o        (m_ch),
    .m_last_o      (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic        v0;
    logic        v1;
    logic        rdy;
    logic        e_valid;
    logic        e_ch;
    logic        e_last;
    logic        e_r0;
    logic        e_r1;
    logic [23:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] en, input logic v0, input logic v1, input logic rdy,
                     input logic ev, input logic ech, input logic el, input logic er0,
                     input logic er1, input logic [23:0] ed);
    vec_t r;
    r.en = en; r.v0 = v0; r.v1 = v1; r.rdy = rdy;
    r.e_valid = ev; r.e_ch = ech; r.e_last = el; r.e_r0 = er0; r.e_r1 = er1; r.e_data = ed;
    tbl.push_back(r);
  endtask

  // Applies reset for one edge, checks the forced outputs, then releases it.
  task automatic do_reset;
    tick;
    rst = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick;
    #4;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_r0", s0_ready, 1'b0);
    chk("rst_r1", s1_ready, 1'b0);
    chk("rst_ch", m_ch, 1'b1);
    chk("rst_data", m_data, 24'h0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   beats;
    int   last_at;
    logic seen;
    logic last_flag;

    // Alternating bursts of 4, then ch1 disabled during its burst.
    add(2'b11, 1, 1, 1, 0, 1, 0, 0, 0, 24'h0);
    for (int i = 0; i < 3; i++) add(2'b11, 1, 1, 1, 1, 0, 0, 1, 0, D0);
    add(2'b11, 1, 1, 1, 1, 0, 1, 1, 0, D0);
    add(2'b11, 1, 1, 1, 0, 0, 0, 0, 0, D0);
    add(2'b11, 1, 1, 1, 1, 1, 0, 0, 1, D1);
    add(2'b01, 1, 1, 1, 1, 1, 0, 0, 1, D1);
    add(2'b01, 1, 1, 1, 1, 1, 0, 0, 1, D1);
    add(2'b01, 1, 1, 1, 1, 1, 1, 0, 1, D1);
    add(2'b01, 1, 1, 1, 0, 1, 0, 0, 0, D1);
    for (int i = 0; i < 3; i++) add(2'b01, 1, 1, 1, 1, 0, 0, 1, 0, D0);
    add(2'b01, 1, 1, 1, 1, 0, 1, 1, 0, D0);
    add(2'b01, 1, 1, 1, 0, 0, 0, 0, 0, D0);
    for (int i = 0; i < 3; i++) add(2'b01, 1, 1, 1, 1, 0, 0, 1, 0, D0);
    add(2'b01, 1, 1, 1, 1, 0, 1, 1, 0, D0);

    do_reset();
    cfg_burst_len = 8'd4;
    foreach (tbl[i]) begin
      tick;
      cfg_ch_en = tbl[i].en;
      s0_valid  = tbl[i].v0;
      s1_valid  = tbl[i].v1;
      m_ready   = tbl[i].rdy;
      #4;
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ch", i), m_ch, tbl[i].e_ch);
      chk($sformatf("tbl%0d_last", i), m_last, tbl[i].e_last);
      chk($sformatf("tbl%0d_r0", i), s0_ready, tbl[i].e_r0);
      chk($sformatf("tbl%0d_r1", i), s1_ready, tbl[i].e_r1);
      chk($sformatf("tbl%0d_data", i), m_data, tbl[i].e_data);
      $display("row %0d: valid=%0b ch=%0d last=%0b data=%06h", i, m_valid, m_ch, m_last, m_data);
    end

    // Length 0 means 256 beats; last only on the 256th, then one bubble.
    do_reset();
    cfg_ch_en = 2'b01; cfg_burst_len = 8'd0; m_ready = 1'b1;
    s0_data = D0; s0_valid = 1'b1; s1_valid = 1'b0;
    seen = 1'b0; beats = 0; last_at = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick;
      #4;
      if (m_valid && s0_ready) beats++;
      if (m_last) begin
        seen = 1'b1;
        last_at = beats;
      end
    end
    chk("b256_last_seen", seen, 1'b1);
    chk("b256_last_beat", last_at, 256);
    tick; #4;
    chk("b256_bubble_valid", m_valid, 1'b0);
    chk("b256_bubble_ch", m_ch, 1'b0);
    tick; #4;
    chk("b256_regrant", m_valid, 1'b1);
    $display("long burst: %0d beats, last on beat %0d", beats, last_at);

    // Idle timeout: 3 beats, then ch0 goes quiet for 16 cycles.
    do_reset();
    cfg_ch_en = 2'b11; cfg_burst_len = 8'd8; m_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    last_flag = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick; #4;
      chk($sformatf("to_beat%0d_valid", b), m_valid, 1'b1);
      chk($sformatf("to_beat%0d_ch", b), m_ch, 1'b0);
      if (m_last) last_flag = 1'b1;
    end
    tick;
    s0_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick;
      #4;
      chk($sformatf("to_held%0d", i), s0_ready, 1'b1);
      if (m_last) last_flag = 1'b1;
    end
    tick; #4;
    chk("to_revoked_r0", s0_ready, 1'b0);
    chk("to_revoked_valid", m_valid, 1'b0);
    chk("to_revoked_ch", m_ch, 1'b0);
    tick; #4;
    chk("to_next_ch", m_ch, 1'b1);
    chk("to_next_valid", m_valid, 1'b1);
    chk("to_next_r1", s1_ready, 1'b1);
    chk("to_no_last", last_flag, 1'b0);
    $display("timeout: ch0 revoked after 16 idle cycles, ch1 granted");

    // 40-cycle downstream stall mid-burst: no timeout, data held.
    do_reset();
    cfg_ch_en = 2'b01; cfg_burst_len = 8'd4; m_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b0;
    k = 0; s0_data = D0;
    for (int b = 0; b < 2; b++) begin
      tick;
      s0_data = D0 + 24'(k);
      #4;
      chk($sformatf("st_beat%0d_data", b), m_data, D0 + 24'(k));
      chk($sformatf("st_beat%0d_valid", b), m_valid, 1'b1);
      if (s0_ready && s0_valid) k++;
    end
    tick;
    m_ready = 1'b0;
    s0_data = D0 + 24'(k);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) tick;
      #4;
      chk($sformatf("st_stall%0d_valid", i), m_valid, 1'b1);
      chk($sformatf("st_stall%0d_data", i), m_data, D0 + 24'd2);
      chk($sformatf("st_stall%0d_last", i), m_last, 1'b0);
    end
    tick;
    m_ready = 1'b1;
    #4;
    chk("st_beat3_data", m_data, D0 + 24'd2);
    chk("st_beat3_last", m_last, 1'b0);
    if (s0_ready && s0_valid) k++;
    tick;
    s0_data = D0 + 24'(k);
    #4;
    chk("st_beat4_data", m_data, D0 + 24'd3);
    chk("st_beat4_last", m_last, 1'b1);
    tick; #4;
    chk("st_bubble_valid", m_valid, 1'b0);
    chk("st_bubble_hold", m_data, D0 + 24'd3);
    $display("stall: burst completed after 40-cycle stall");

    // Reset during beat 2 aborts the burst; ch0 wins the first tie.
    do_reset();
    cfg_ch_en = 2'b11; cfg_burst_len = 8'd4; m_ready = 1'b1;
    s0_data = D0; s0_valid = 1'b1; s1_valid = 1'b1;
    tick; #4;
    chk("mr_beat1_valid", m_valid, 1'b1);
    tick;
    rst = 1'b1;
    #4;
    chk("mr_in_rst_valid", m_valid, 1'b0);
    chk("mr_in_rst_last", m_last, 1'b0);
    chk("mr_in_rst_r0", s0_ready, 1'b0);
    chk("mr_in_rst_ch", m_ch, 1'b1);
    chk("mr_in_rst_data", m_data, 24'h0);
    tick;
    rst = 1'b0;
    #4;
    chk("mr_first_valid", m_valid, 1'b0);
    chk("mr_first_ch", m_ch, 1'b1);
    tick; #4;
    chk("mr_grant_ch", m_ch, 1'b0);
    chk("mr_grant_valid", m_valid, 1'b1);
    chk("mr_grant_r0", s0_ready, 1'b1);
    $display("mid-burst reset: first grant to ch%0d", m_ch);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
